// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer: stage/index loop controller for the FFT twiddle path.
// Ports: clk, rst (sync, active-high); i_start/i_forward_in/i_log_n request a transform,
// i_stall holds the current index; o_busy/o_done report status; o_tw_rst, o_is_forward_fft,
// o_m, o_i, o_i_loop_done drive the twiddle storage; o_valid marks an issued (o_m, o_i).
module fft_twiddle_sequencer #(
  parameter int MAX_LOG_N = 13,
  parameter int DRAIN_FWD = 11,
  parameter int DRAIN_INV = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_forward_in,
  input  logic [3:0]           i_log_n,
  input  logic                 i_stall,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_tw_rst,
  output logic                 o_is_forward_fft,
  output logic [MAX_LOG_N-1:0] o_m,
  output logic [MAX_LOG_N-1:0] o_i,
  output logic                 o_i_loop_done,
  output logic                 o_valid
);
  localparam int DMAX = DRAIN_FWD > DRAIN_INV ? DRAIN_FWD : DRAIN_INV;
  localparam int CW = $clog2(DMAX + 1);
  typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;
  state_t r_state, w_next;
  logic r_fwd;
  logic [3:0] r_log, w_log;
  logic [MAX_LOG_N-1:0] r_m, r_i, w_m_top, w_m_end;
  logic [CW-1:0] r_cnt;
  logic w_wrap, w_last;
  assign w_log = i_log_n == 4'd0 ? 4'd1 : i_log_n > 4'(MAX_LOG_N) ? 4'(MAX_LOG_N) : i_log_n;
  assign w_m_top = MAX_LOG_N'(1) << (r_log - 4'd1);
  // final stage size: forward walks down to 1, inverse walks up to 2^(L-1)
  assign w_m_end = r_fwd ? MAX_LOG_N'(1) : w_m_top;
  assign w_wrap = r_i == r_m - MAX_LOG_N'(1);
  assign w_last = w_wrap && r_m == w_m_end;
  assign o_m = r_m;
  assign o_i = r_i;
  assign o_is_forward_fft = r_fwd;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    o_busy = !rst && r_state != IDLE;
    o_done = !rst && r_state == DONE;
    o_tw_rst = rst || r_state == INIT;
    o_valid = !rst && r_state == RUN && !i_stall;
    o_i_loop_done = o_valid && w_wrap;
    case (r_state)
      IDLE:    w_next = i_start ? INIT : IDLE;
      INIT:    w_next = RUN;
      RUN:     w_next = o_valid && w_last ? DRAIN : RUN;
      DRAIN:   w_next = r_cnt == CW'(1) ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  // the last issue leaves m/i untouched so they hold their final values through DRAIN
  always_ff @(posedge clk)
    if (rst) begin
      r_fwd <= 1'b0;
      r_log <= 4'd0;
      r_m <= '0;
      r_i <= '0;
      r_cnt <= '0;
    end else if (r_state == IDLE && i_start) begin
      r_fwd <= i_forward_in;
      r_log <= w_log;
    end else if (r_state == INIT) begin
      r_i <= '0;
      r_m <= r_fwd ? w_m_top : MAX_LOG_N'(1);
    end else if (o_valid) begin
      if (w_last) r_cnt <= r_fwd ? CW'(DRAIN_FWD) : CW'(DRAIN_INV);
      else if (w_wrap) begin
        r_i <= '0;
        r_m <= r_fwd ? r_m >> 1 : r_m << 1;
      end else r_i <= r_i + MAX_LOG_N'(1);
    end else if (r_state == DRAIN) r_cnt <= r_cnt - CW'(1);
endmodule
